// File: rtl/id_ex_latch.sv
// -----------------------------------------------------------------------------
// id_ex_latch
//
// Pipeline register between the ID and EX stages of the MIPS core.
// Captures the PC+8 return address, both register-file operands, the extended
// immediate, the register specifiers and the decoded control bundle, and
// presents them to EX one cycle later.
//
// Update priority at each rising edge, highest first:
//   reset (active low) > debug freeze (i_enable==0) > flush > stall > load
//
// A bubble is either a flush or a load of an invalid ID slot. A bubble clears
// the whole control bundle, including valid, while the data and specifier
// fields are still loaded so the debug unit can see what was squashed. Each
// bubble bumps a saturating counter that only reset clears.
//
// Ports:
//   i_clk            core clock, rising edge
//   i_reset          synchronous active-low reset
//   i_enable         debug run/step enable; 0 freezes every register
//   i_stall          hold current contents
//   i_flush          load a bubble instead of the ID contents
//   i_id_*           ID-stage fields (data, specifiers, control, valid)
//   o_ex_*           registered copy of each i_id_* field
//   o_bubble_count   saturating count of bubbles since reset
// -----------------------------------------------------------------------------
module id_ex_latch #(
   parameter int BITS_DATA    = 32,
   parameter int BITS_REG     = 5,
   parameter int BITS_ALUOP   = 4,
   parameter int BITS_BUBBLES = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_enable,
   input  logic                    i_stall,
   input  logic                    i_flush,
   input  logic                    i_id_valid,
   input  logic [BITS_DATA-1:0]    i_id_pc8,
   input  logic [BITS_DATA-1:0]    i_id_data_a,
   input  logic [BITS_DATA-1:0]    i_id_data_b,
   input  logic [BITS_DATA-1:0]    i_id_extension,
   input  logic [BITS_REG-1:0]     i_id_rs,
   input  logic [BITS_REG-1:0]     i_id_rt,
   input  logic [BITS_REG-1:0]     i_id_rd,
   input  logic [BITS_REG-1:0]     i_id_shamt,
   input  logic [BITS_ALUOP-1:0]   i_id_alu_op,
   input  logic [1:0]              i_id_alu_src,
   input  logic [1:0]              i_id_reg_dst,
   input  logic [1:0]              i_id_mem_width,
   input  logic                    i_id_mem_read,
   input  logic                    i_id_mem_write,
   input  logic                    i_id_mem_sign,
   input  logic                    i_id_reg_write,
   input  logic                    i_id_mem_to_reg,
   input  logic                    i_id_halt,
   output logic                    o_ex_valid,
   output logic [BITS_DATA-1:0]    o_ex_pc8,
   output logic [BITS_DATA-1:0]    o_ex_data_a,
   output logic [BITS_DATA-1:0]    o_ex_data_b,
   output logic [BITS_DATA-1:0]    o_ex_extension,
   output logic [BITS_REG-1:0]     o_ex_rs,
   output logic [BITS_REG-1:0]     o_ex_rt,
   output logic [BITS_REG-1:0]     o_ex_rd,
   output logic [BITS_REG-1:0]     o_ex_shamt,
   output logic [BITS_ALUOP-1:0]   o_ex_alu_op,
   output logic [1:0]              o_ex_alu_src,
   output logic [1:0]              o_ex_reg_dst,
   output logic [1:0]              o_ex_mem_width,
   output logic                    o_ex_mem_read,
   output logic                    o_ex_mem_write,
   output logic                    o_ex_mem_sign,
   output logic                    o_ex_reg_write,
   output logic                    o_ex_mem_to_reg,
   output logic                    o_ex_halt,
   output logic [BITS_BUBBLES-1:0] o_bubble_count
);

   // Decoded control bundle. Every member is cleared by a bubble, which is
   // what keeps mem_write/reg_write/halt from ever being set while valid is 0.
   typedef struct packed {
      logic [BITS_ALUOP-1:0] alu_op;
      logic [1:0]            alu_src;
      logic [1:0]            reg_dst;
      logic [1:0]            mem_width;
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem_sign;
      logic                  reg_write;
      logic                  mem_to_reg;
      logic                  halt;
      logic                  valid;
   } ctrl_t;

   localparam logic [BITS_BUBBLES-1:0] COUNT_MAX = {BITS_BUBBLES{1'b1}};

   ctrl_t                   ctrl_d;
   ctrl_t                   ex_ctrl;
   logic                    bubble;
   logic                    load;
   logic                    count_inc;
   logic [BITS_BUBBLES-1:0] bubble_count;

   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      ctrl_d     = '0;
      bubble     = i_flush | ~i_id_valid;
      // A flush overrides a stall; otherwise a stall holds everything.
      load       = i_enable & (i_flush | ~i_stall);
      count_inc  = load & bubble & (bubble_count != COUNT_MAX);
      if (!bubble) begin
         ctrl_d.alu_op     = i_id_alu_op;
         ctrl_d.alu_src    = i_id_alu_src;
         ctrl_d.reg_dst    = i_id_reg_dst;
         ctrl_d.mem_width  = i_id_mem_width;
         ctrl_d.mem_read   = i_id_mem_read;
         ctrl_d.mem_write  = i_id_mem_write;
         ctrl_d.mem_sign   = i_id_mem_sign;
         ctrl_d.reg_write  = i_id_reg_write;
         ctrl_d.mem_to_reg = i_id_mem_to_reg;
         ctrl_d.halt       = i_id_halt;
         ctrl_d.valid      = 1'b1;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         ex_ctrl        <= '0;
         o_ex_pc8       <= '0;
         o_ex_data_a    <= '0;
         o_ex_data_b    <= '0;
         o_ex_extension <= '0;
         o_ex_rs        <= '0;
         o_ex_rt        <= '0;
         o_ex_rd        <= '0;
         o_ex_shamt     <= '0;
         bubble_count   <= '0;
      end else if (load) begin
         // Data and specifiers load even on a bubble, for debug visibility.
         ex_ctrl        <= ctrl_d;
         o_ex_pc8       <= i_id_pc8;
         o_ex_data_a    <= i_id_data_a;
         o_ex_data_b    <= i_id_data_b;
         o_ex_extension <= i_id_extension;
         o_ex_rs        <= i_id_rs;
         o_ex_rt        <= i_id_rt;
         o_ex_rd        <= i_id_rd;
         o_ex_shamt     <= i_id_shamt;
         if (count_inc) begin
            bubble_count <= bubble_count + 1'b1;
         end
      end
   end

   assign o_ex_valid      = ex_ctrl.valid;
   assign o_ex_alu_op     = ex_ctrl.alu_op;
   assign o_ex_alu_src    = ex_ctrl.alu_src;
   assign o_ex_reg_dst    = ex_ctrl.reg_dst;
   assign o_ex_mem_width  = ex_ctrl.mem_width;
   assign o_ex_mem_read   = ex_ctrl.mem_read;
   assign o_ex_mem_write  = ex_ctrl.mem_write;
   assign o_ex_mem_sign   = ex_ctrl.mem_sign;
   assign o_ex_reg_write  = ex_ctrl.reg_write;
   assign o_ex_mem_to_reg = ex_ctrl.mem_to_reg;
   assign o_ex_halt       = ex_ctrl.halt;
   assign o_bubble_count  = bubble_count;

endmodule

// File: tb/tb_id_ex_latch.sv
// -----------------------------------------------------------------------------
// tb_id_ex_latch
//
// Directed bench for id_ex_latch with hand-computed expectations. The DUT is
// built with a 4-bit bubble counter so saturation is reachable quickly.
// Inputs are driven 1 ns after the rising edge and outputs are sampled at the
// same point, i.e. after the edge that registered them.
// -----------------------------------------------------------------------------
module tb_id_ex_latch;

   localparam int BD = 32;
   localparam int BR = 5;
   localparam int BA = 4;
   localparam int BB = 4;

   logic          clk;
   logic          reset;
   logic          enable;
   logic          stall;
   logic          flush;
   logic          id_valid;
   logic [BD-1:0] id_pc8, id_data_a, id_data_b, id_extension;
   logic [BR-1:0] id_rs, id_rt, id_rd, id_shamt;
   logic [BA-1:0] id_alu_op;
   logic [1:0]    id_alu_src, id_reg_dst, id_mem_width;
   logic          id_mem_read, id_mem_write, id_mem_sign;
   logic          id_reg_write, id_mem_to_reg, id_halt;

   logic          ex_valid;
   logic [BD-1:0] ex_pc8, ex_data_a, ex_data_b, ex_extension;
   logic [BR-1:0] ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [BA-1:0] ex_alu_op;
   logic [1:0]    ex_alu_src, ex_reg_dst, ex_mem_width;
   logic          ex_mem_read, ex_mem_write, ex_mem_sign;
   logic          ex_reg_write, ex_mem_to_reg, ex_halt;
   logic [BB-1:0] bubble_count;

   int n_checks = 0;
   int n_fails  = 0;

   id_ex_latch #(
      .BITS_DATA   (BD),
      .BITS_REG    (BR),
      .BITS_ALUOP  (BA),
      .BITS_BUBBLES(BB)
   ) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_enable       (enable),
      .i_stall        (stall),
      .i_flush        (flush),
      .i_id_valid     (id_valid),
      .i_id_pc8       (id_pc8),
      .i_id_data_a    (id_data_a),
      .i_id_data_b    (id_data_b),
      .i_id_extension (id_extension),
      .i_id_rs        (id_rs),
      .i_id_rt        (id_rt),
      .i_id_rd        (id_rd),
      .i_id_shamt     (id_shamt),
      .i_id_alu_op    (id_alu_op),
      .i_id_alu_src   (id_alu_src),
      .i_id_reg_dst   (id_reg_dst),
      .i_id_mem_width (id_mem_width),
      .i_id_mem_read  (id_mem_read),
      .i_id_mem_write (id_mem_write),
      .i_id_mem_sign  (id_mem_sign),
      .i_id_reg_write (id_reg_write),
      .i_id_mem_to_reg(id_mem_to_reg),
      .i_id_halt      (id_halt),
      .o_ex_valid     (ex_valid),
      .o_ex_pc8       (ex_pc8),
      .o_ex_data_a    (ex_data_a),
      .o_ex_data_b    (ex_data_b),
      .o_ex_extension (ex_extension),
      .o_ex_rs        (ex_rs),
      .o_ex_rt        (ex_rt),
      .o_ex_rd        (ex_rd),
      .o_ex_shamt     (ex_shamt),
      .o_ex_alu_op    (ex_alu_op),
      .o_ex_alu_src   (ex_alu_src),
      .o_ex_reg_dst   (ex_reg_dst),
      .o_ex_mem_width (ex_mem_width),
      .o_ex_mem_read  (ex_mem_read),
      .o_ex_mem_write (ex_mem_write),
      .o_ex_mem_sign  (ex_mem_sign),
      .o_ex_reg_write (ex_reg_write),
      .o_ex_mem_to_reg(ex_mem_to_reg),
      .o_ex_halt      (ex_halt),
      .o_bubble_count (bubble_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One rising edge, then settle 1 ns before sampling / driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_id();
      id_valid      = 1'b0;
      id_pc8        = '0;
      id_data_a     = '0;
      id_data_b     = '0;
      id_extension  = '0;
      id_rs         = '0;
      id_rt         = '0;
      id_rd         = '0;
      id_shamt      = '0;
      id_alu_op     = '0;
      id_alu_src    = '0;
      id_reg_dst    = '0;
      id_mem_width  = '0;
      id_mem_read   = 1'b0;
      id_mem_write  = 1'b0;
      id_mem_sign   = 1'b0;
      id_reg_write  = 1'b0;
      id_mem_to_reg = 1'b0;
      id_halt       = 1'b0;
   endtask

   task automatic random_id();
      id_valid      = 1'($urandom);
      id_pc8        = $urandom;
      id_data_a     = $urandom;
      id_data_b     = $urandom;
      id_extension  = $urandom;
      id_rs         = 5'($urandom);
      id_rt         = 5'($urandom);
      id_rd         = 5'($urandom);
      id_shamt      = 5'($urandom);
      id_alu_op     = 4'($urandom);
      id_alu_src    = 2'($urandom);
      id_reg_dst    = 2'($urandom);
      id_mem_width  = 2'($urandom);
      id_mem_read   = 1'($urandom);
      id_mem_write  = 1'($urandom);
      id_mem_sign   = 1'($urandom);
      id_reg_write  = 1'($urandom);
      id_mem_to_reg = 1'($urandom);
      id_halt       = 1'($urandom);
   endtask

   // A store word: base 0x100 + 4, store rt=9 value 0xDEADBEEF.
   task automatic load_sw();
      clear_id();
      id_valid     = 1'b1;
      id_data_a    = 32'h0000_0100;
      id_data_b    = 32'hDEAD_BEEF;
      id_extension = 32'h0000_0004;
      id_rs        = 5'd8;
      id_rt        = 5'd9;
      id_alu_src   = 2'b01;
      id_mem_width = 2'b10;
      id_mem_write = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".valid"},      32'(ex_valid),      32'd0);
      check({tag, ".pc8"},        ex_pc8,             32'd0);
      check({tag, ".data_a"},     ex_data_a,          32'd0);
      check({tag, ".data_b"},     ex_data_b,          32'd0);
      check({tag, ".extension"},  ex_extension,       32'd0);
      check({tag, ".regs"},       32'({ex_rs, ex_rt, ex_rd, ex_shamt}), 32'd0);
      check({tag, ".alu"},        32'({ex_alu_op, ex_alu_src, ex_reg_dst, ex_mem_width}), 32'd0);
      check({tag, ".ctrl"},       32'({ex_mem_read, ex_mem_write, ex_mem_sign,
                                       ex_reg_write, ex_mem_to_reg, ex_halt}), 32'd0);
      check({tag, ".count"},      32'(bubble_count),  32'd0);
   endtask

   initial begin
      // ---------------- reset with random inputs ----------------
      reset  = 1'b0;
      enable = 1'($urandom);
      stall  = 1'($urandom);
      flush  = 1'($urandom);
      random_id();
      #1;
      step();
      random_id();
      step();
      check_all_zero("reset");

      // ---------------- first valid add ----------------
      reset  = 1'b1;
      enable = 1'b1;
      stall  = 1'b0;
      flush  = 1'b0;
      clear_id();
      id_valid     = 1'b1;
      id_data_a    = 32'd5;
      id_data_b    = 32'd7;
      id_rs        = 5'd1;
      id_rt        = 5'd2;
      id_rd        = 5'd3;
      id_alu_op    = 4'h2;
      id_reg_dst   = 2'b01;
      id_reg_write = 1'b1;
      step();
      check("add.data_a",    ex_data_a,           32'd5);
      check("add.data_b",    ex_data_b,           32'd7);
      check("add.rd",        32'(ex_rd),          32'd3);
      check("add.alu_op",    32'(ex_alu_op),      32'h2);
      check("add.reg_dst",   32'(ex_reg_dst),     32'h1);
      check("add.reg_write", 32'(ex_reg_write),   32'd1);
      check("add.valid",     32'(ex_valid),       32'd1);
      check("add.count",     32'(bubble_count),   32'd0);

      // ---------------- immediate pass-through ----------------
      clear_id();
      id_valid     = 1'b1;
      id_extension = 32'hFFFF_8000;
      id_alu_src   = 2'b01;
      id_reg_write = 1'b1;
      step();
      check("imm_neg.extension", ex_extension,         32'hFFFF_8000);
      check("imm_neg.alu_src",   32'(ex_alu_src),      32'h1);
      id_extension = 32'h8000_0000;
      step();
      check("imm_lui.extension", ex_extension,         32'h8000_0000);
      check("imm_lui.alu_src",   32'(ex_alu_src),      32'h1);

      // ---------------- stall holds a store ----------------
      load_sw();
      step();
      check("sw.mem_write",  32'(ex_mem_write),  32'd1);
      check("sw.data_b",     ex_data_b,          32'hDEAD_BEEF);
      check("sw.mem_width",  32'(ex_mem_width),  32'h2);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         clear_id();
         id_valid     = 1'b1;
         id_data_b    = 32'h0000_1234 + 32'(i);
         id_reg_write = 1'b1;
         step();
         check("stall.data_b",    ex_data_b,          32'hDEAD_BEEF);
         check("stall.mem_write", 32'(ex_mem_write),  32'd1);
         check("stall.reg_write", 32'(ex_reg_write),  32'd0);
         check("stall.count",     32'(bubble_count),  32'd0);
      end
      stall = 1'b0;
      step();
      check("unstall.data_b",    ex_data_b,          32'h0000_1236);
      check("unstall.reg_write", 32'(ex_reg_write),  32'd1);
      check("unstall.mem_write", 32'(ex_mem_write),  32'd0);

      // ---------------- flush beats stall ----------------
      load_sw();
      flush = 1'b1;
      stall = 1'b1;
      step();
      check("flush.mem_write", 32'(ex_mem_write),  32'd0);
      check("flush.valid",     32'(ex_valid),      32'd0);
      check("flush.data_b",    ex_data_b,          32'hDEAD_BEEF);
      check("flush.rt",        32'(ex_rt),         32'd9);
      check("flush.alu_src",   32'(ex_alu_src),    32'd0);
      check("flush.mem_width", 32'(ex_mem_width),  32'd0);
      check("flush.count",     32'(bubble_count),  32'd1);

      // ---------------- debug freeze ----------------
      flush = 1'b0;
      stall = 1'b0;
      clear_id();
      id_valid     = 1'b1;
      id_data_a    = 32'h0000_AAAA;
      id_reg_write = 1'b1;
      step();
      check("prefreeze.data_a", ex_data_a, 32'h0000_AAAA);
      enable = 1'b0;
      flush  = 1'b1;
      id_data_a = 32'h0000_BBBB;
      for (int i = 0; i < 4; i++) begin
         step();
         check("freeze.data_a",    ex_data_a,          32'h0000_AAAA);
         check("freeze.valid",     32'(ex_valid),      32'd1);
         check("freeze.reg_write", 32'(ex_reg_write),  32'd1);
         check("freeze.count",     32'(bubble_count),  32'd1);
      end
      enable = 1'b1;
      step();
      check("unfreeze.valid",     32'(ex_valid),      32'd0);
      check("unfreeze.reg_write", 32'(ex_reg_write),  32'd0);
      check("unfreeze.data_a",    ex_data_a,          32'h0000_BBBB);
      check("unfreeze.count",     32'(bubble_count),  32'd2);

      // ---------------- invalid ID slot becomes a bubble ----------------
      flush = 1'b0;
      clear_id();
      id_valid     = 1'b0;
      id_data_a    = 32'h0000_CCCC;
      id_reg_write = 1'b1;
      id_mem_write = 1'b1;
      id_halt      = 1'b1;
      id_alu_op    = 4'hF;
      step();
      check("invalid.data_a", ex_data_a, 32'h0000_CCCC);
      check("invalid.ctrl",   32'({ex_mem_write, ex_reg_write, ex_halt, ex_valid}), 32'd0);
      check("invalid.alu_op", 32'(ex_alu_op),     32'd0);
      check("invalid.count",  32'(bubble_count),  32'd3);

      // ---------------- full field pass-through ----------------
      clear_id();
      id_valid      = 1'b1;
      id_pc8        = 32'h0040_1008;
      id_rs         = 5'd1;
      id_rt         = 5'd2;
      id_rd         = 5'd31;
      id_shamt      = 5'd17;
      id_alu_op     = 4'hA;
      id_alu_src    = 2'b10;
      id_reg_dst    = 2'b10;
      id_mem_width  = 2'b01;
      id_mem_read   = 1'b1;
      id_mem_sign   = 1'b1;
      id_reg_write  = 1'b1;
      id_mem_to_reg = 1'b1;
      id_halt       = 1'b1;
      step();
      check("full.pc8",   ex_pc8, 32'h0040_1008);
      check("full.regs",  32'({ex_rs, ex_rt, ex_rd, ex_shamt}),
                          32'({5'd1, 5'd2, 5'd31, 5'd17}));
      check("full.alu",   32'({ex_alu_op, ex_alu_src, ex_reg_dst, ex_mem_width}),
                          32'({4'hA, 2'b10, 2'b10, 2'b01}));
      check("full.ctrl",  32'({ex_mem_read, ex_mem_write, ex_mem_sign,
                               ex_reg_write, ex_mem_to_reg, ex_halt, ex_valid}),
                          32'(7'b1011111));
      check("full.count", 32'(bubble_count), 32'd3);

      // ---------------- saturation (4-bit counter) ----------------
      flush = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         check("sat.count", 32'(bubble_count), (4 + i > 15) ? 32'd15 : 32'(4 + i));
         check("sat.invariant",
               32'((ex_mem_write | ex_reg_write | ex_halt) & ~ex_valid), 32'd0);
      end

      // ---------------- reset mid-flush and mid-stall ----------------
      reset = 1'b0;
      stall = 1'b1;
      random_id();
      step();
      check_all_zero("reset_mid");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
- Pipeline register between ID and EX of the MIPS core.
- Captures the 32-bit immediate already extended in ID, the register-file read operands, the register specifiers, and the decoded control bundle. Presents them to EX on the next cycle.
- Supports debug-unit gating, hold (stall), and bubble insertion (flush).
- Keeps a saturating count of bubbles inserted, read by the debug unit.

Parameters:
- BITS_DATA, 32, width of PC+8, operand and immediate fields
- BITS_REG, 5, width of rs/rt/rd/shamt specifiers
- BITS_ALUOP, 4, width of ALU operation code
- BITS_BUBBLES, 16, width of bubble counter

Ports:
- i_clk  in  1  core clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_enable  in  1  debug-unit run/step enable; 0 freezes all state
- i_stall  in  1  hold current contents (EX not ready)
- i_flush  in  1  load a bubble instead of ID contents
- i_id_valid  in  1  ID holds a real instruction
- i_id_pc8  in  BITS_DATA  return address for jal/jalr
- i_id_data_a  in  BITS_DATA  rs read value
- i_id_data_b  in  BITS_DATA  rt read value
- i_id_extension  in  BITS_DATA  extended immediate from ID
- i_id_rs / i_id_rt / i_id_rd / i_id_shamt  in  BITS_REG each  specifiers
- i_id_alu_op  in  BITS_ALUOP  ALU function
- i_id_alu_src  in  2  ALU B source: 00 reg, 01 immediate, 10 shamt
- i_id_reg_dst  in  2  dest select: 00 rt, 01 rd, 10 r31
- i_id_mem_width  in  2  00 byte, 01 half, 10 word
- i_id_mem_read / i_id_mem_write / i_id_mem_sign / i_id_reg_write / i_id_mem_to_reg / i_id_halt  in  1 each  control bits
- o_ex_*  out  same widths  registered copy of every i_id_* input above, including o_ex_valid
- o_bubble_count  out  BITS_BUBBLES  bubbles inserted since reset, saturating

Behaviour:
- Latency: one cycle. ID values sampled at edge N appear on o_ex_* after edge N.
- Update priority is evaluated at each rising edge, highest first:
  1. i_reset==0: every output is 0. This includes data fields, all control bits, o_ex_valid and o_bubble_count. It takes effect on the edge regardless of the other inputs, including mid-stall and mid-flush.
  2. i_enable==0: all registers hold, counter included. Stall and flush are ignored.
  3. i_flush==1: bubble.
     - Control bits cleared: mem_read, mem_write, reg_write, mem_to_reg, halt, valid.
     - alu_op, alu_src, reg_dst, mem_width and mem_sign are also cleared to 0.
     - Data and specifier fields are still loaded from ID, so they remain observable for debug.
     - Counter increments.
     - Flush wins over a simultaneous stall.
  4. i_stall==1: all registers hold. The counter does not increment.
  5. Otherwise: load every field from ID.
     - If i_id_valid==0 the loaded control bits are forced to the bubble values of step 3 (valid=0). The counter increments.
     - If i_id_valid==1 all fields are loaded unmodified and the counter is unchanged.
- Counter:
  - Increments by 1 per bubble.
  - Saturates at 2^BITS_BUBBLES-1; no wrap.
  - Cleared only by reset.
- Invariant: o_ex_mem_write, o_ex_reg_write and o_ex_halt are never 1 while o_ex_valid==0.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold i_reset=0 with random inputs for 2 edges -> all o_ex_* = 0, o_bubble_count = 0. Release, load valid add (data_a=5, data_b=7, rd=3, reg_write=1) -> after one edge o_ex_data_a=5, o_ex_rd=3, o_ex_reg_write=1, o_ex_valid=1.
- Immediate pass-through: i_id_extension=32'hFFFF8000, alu_src=01 -> next cycle o_ex_extension=32'hFFFF8000, o_ex_alu_src=01. Repeat with 32'h80000000 (lui form) -> identical passthrough.
- Stall: load sw (mem_write=1, valid=1), then i_stall=1 for 3 cycles while ID changes -> outputs frozen at the sw values, counter unchanged. Deassert -> next ID value loaded.
- Flush vs stall: i_flush=1 and i_stall=1 on the same edge with ID holding sw -> o_ex_mem_write=0, o_ex_valid=0, o_ex_data_b equals ID value, counter +1.
- Debug freeze: i_enable=0 for 4 cycles with i_flush=1 -> no output or counter change. Set i_enable=1 -> bubble on the next edge.
- Saturation: BITS_BUBBLES=4, apply 20 consecutive flushes -> counter stops at 15. Reset mid-run -> counter 0 on that edge.
